// File: rtl/cnt_seq_pkg.sv
// Shared types and helpers for the counter run sequencer.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_e;

  // Steps in one full period of the downstream 4-bit down counter.
  localparam int CNT_PERIOD = 16;

  function automatic int prescale_w(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: tick is high on the cycle the prescaler reads zero.
module tick_gen
  import cnt_seq_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (clr || (pre_q == LAST)) begin
      pre_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = (pre_q == '0);

endmodule

// File: rtl/cnt_sequencer.sv
// Run controller for a 4-bit down counter: paces its enable and stops after a
// requested number of full periods, with ready/start handshake and done pulse.
module cnt_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WRAP_W   = 4,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WRAP_W-1:0] wraps,
  input  logic              abort,
  input  logic              co,
  output logic              ready,
  output logic              busy,
  output logic              cnt,
  output logic              cnt_rst,
  output logic              done
);

  state_e            state_q, state_d;
  logic [WRAP_W-1:0] wraps_q;
  logic [WRAP_W-1:0] arrivals_q;
  logic              cnt_q;
  logic              tick;
  logic              accept;
  logic              arrival;
  logic              final_arrival;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (state_q != ST_RUN),
    .tick(tick)
  );

  assign accept        = (state_q == ST_IDLE) && start && !abort;
  // The counter just stepped from 0001 to 0000 when our last enable is seen with co low.
  assign arrival       = (state_q == ST_RUN) && cnt_q && !co;
  assign final_arrival = arrival && (arrivals_q == (wraps_q - WRAP_W'(1)));

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    cnt     = 1'b0;
    cnt_rst = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready   = 1'b1;
        cnt_rst = 1'b1;
        if (accept) begin
          state_d = (wraps == '0) ? ST_DONE : ST_ARM;
        end
      end
      ST_ARM: begin
        busy    = 1'b1;
        state_d = abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        cnt  = tick && !final_arrival && !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (final_arrival) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wraps_q    <= '0;
      arrivals_q <= '0;
      cnt_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt;
      if (accept) begin
        wraps_q <= wraps;
      end
      if (state_q != ST_RUN) begin
        arrivals_q <= '0;
      end else if (arrival) begin
        arrivals_q <= arrivals_q + WRAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cnt_sequencer.sv
// Bench for cnt_sequencer: two instances (prescale 1 and 4) each driving a
// behavioural 4-bit down counter, checked cycle by cycle against run formulas.
module tb_cnt_sequencer;
  import cnt_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start_s, abort_s, co_s;
  logic [1:0] ready_s, busy_s, cnt_s, cnt_rst_s, done_s;
  logic [3:0] wraps_s [2];
  logic [3:0] cval    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_unit
    logic       ctr_clr;
    logic [3:0] ctr_q;

    cnt_sequencer #(
      .WRAP_W  (4),
      .PRESCALE((g == 0) ? 1 : 4)
    ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start_s[g]),
      .wraps  (wraps_s[g]),
      .abort  (abort_s[g]),
      .co     (co_s[g]),
      .ready  (ready_s[g]),
      .busy   (busy_s[g]),
      .cnt    (cnt_s[g]),
      .cnt_rst(cnt_rst_s[g]),
      .done   (done_s[g])
    );

    assign ctr_clr = cnt_rst_s[g] | ~rst;

    always @(posedge clk or posedge ctr_clr) begin
      if (ctr_clr) ctr_q <= 4'd0;
      else if (cnt_s[g]) ctr_q <= ctr_q - 4'd1;
    end

    assign cval[g] = ctr_q;
    assign co_s[g] = (ctr_q != 4'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int prescale_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  // Run outcome from the timing rules: done cycle (0 = none) and pulse count.
  function automatic void expect_run(input int p, input int w, input int a,
                                     output int exp_done, output int exp_pulses);
    int dc, last_cnt, lim;
    dc       = (w == 0) ? 1 : (CNT_PERIOD * w - 1) * p + 4;
    last_cnt = (w == 0) ? 0 : 2 + (CNT_PERIOD * w - 1) * p;
    lim      = last_cnt;
    exp_done = dc;
    if (a > 0 && a < dc) begin
      exp_done = 0;
      if (a - 1 < lim) lim = a - 1;
    end
    exp_pulses = (w > 0 && lim >= 2) ? (lim - 2) / p + 1 : 0;
  endfunction

  // Starts one run on unit u from an IDLE negedge and checks every cycle until IDLE returns.
  task automatic run_check(input int u, input int w, input int a,
                           output int done_at, output int pulses);
    int   p, dc, last_cnt, last;
    bit   ab, e_cnt, e_busy;
    logic [4:0] exp_v, act_v;
    p        = prescale_of(u);
    dc       = (w == 0) ? 1 : (CNT_PERIOD * w - 1) * p + 4;
    last_cnt = (w == 0) ? 0 : 2 + (CNT_PERIOD * w - 1) * p;
    ab       = (a > 0 && a < dc);
    last     = ab ? a : dc;
    done_at  = 0;
    pulses   = 0;
    @(negedge clk);
    check($sformatf("u%0d_w%0d_idle_before", u, w), 32'(ready_s[u]), 32'd1);
    start_s[u] = 1'b1;
    wraps_s[u] = 4'(w);
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      start_s[u] = 1'b0;
      abort_s[u] = ab && (k == a);
      #1;
      e_busy = (k <= last);
      e_cnt  = (w > 0) && (k >= 2) && (k <= last_cnt) && ((k - 2) % p == 0) && !(ab && k >= a);
      exp_v  = {!e_busy, e_busy, !e_busy, e_cnt, (!ab && k == dc)};
      act_v  = {ready_s[u], busy_s[u], cnt_rst_s[u], cnt_s[u], done_s[u]};
      check($sformatf("u%0d_w%0d_a%0d_cyc%0d_rdy_bsy_rst_cnt_done", u, w, a, k), 32'(act_v), 32'(exp_v));
      if (cnt_s[u]) pulses++;
      if (done_s[u]) done_at = k;
      if (!ab && k == dc) check($sformatf("u%0d_w%0d_counter_at_done", u, w), 32'(cval[u]), 32'd0);
    end
    abort_s[u] = 1'b0;
  endtask

  typedef struct {
    int u;
    int w;
    int a;
    int exp_done;
    int exp_pulses;
  } vec_t;

  initial begin
    vec_t vecs[12];
    int   d, p, ed, ep, dq[$], p1, p2;

    vecs[0]  = '{u: 0, w: 1,  a: 0,  exp_done: 19,  exp_pulses: 16};
    vecs[1]  = '{u: 1, w: 3,  a: 0,  exp_done: 192, exp_pulses: 48};
    vecs[2]  = '{u: 0, w: 0,  a: 0,  exp_done: 1,   exp_pulses: 0};
    vecs[3]  = '{u: 0, w: 2,  a: 10, exp_done: 0,   exp_pulses: 8};
    vecs[4]  = '{u: 1, w: 1,  a: 0,  exp_done: 64,  exp_pulses: 16};
    vecs[5]  = '{u: 0, w: 15, a: 0,  exp_done: 243, exp_pulses: 240};
    vecs[6]  = '{u: 1, w: 2,  a: 30, exp_done: 0,   exp_pulses: 7};
    vecs[7]  = '{u: 0, w: 1,  a: 1,  exp_done: 0,   exp_pulses: 0};
    vecs[8]  = '{u: 1, w: 0,  a: 0,  exp_done: 1,   exp_pulses: 0};
    vecs[9]  = '{u: 0, w: 3,  a: 17, exp_done: 0,   exp_pulses: 15};
    vecs[10] = '{u: 1, w: 1,  a: 63, exp_done: 0,   exp_pulses: 16};
    vecs[11] = '{u: 1, w: 1,  a: 64, exp_done: 64,  exp_pulses: 16};

    rst     = 1'b0;
    start_s = '0;
    abort_s = '0;
    wraps_s[0] = '0;
    wraps_s[1] = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_reset_rdy_bsy_rst_cnt_done", u),
            32'({ready_s[u], busy_s[u], cnt_rst_s[u], cnt_s[u], done_s[u]}), 32'b10100);
    end
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_check(vecs[i].u, vecs[i].w, vecs[i].a, d, p);
      check($sformatf("vec%0d_done_cycle", i), 32'(d), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_pulses", i), 32'(p), 32'(vecs[i].exp_pulses));
    end

    for (int i = 0; i < 12; i++) begin
      int u, w, a, dc;
      u  = int'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 4));
      dc = (w == 0) ? 1 : (CNT_PERIOD * w - 1) * prescale_of(u) + 4;
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dc + 1)) : 0;
      expect_run(prescale_of(u), w, a, ed, ep);
      run_check(u, w, a, d, p);
      check($sformatf("rand%0d_u%0d_w%0d_a%0d_done_cycle", i, u, w, a), 32'(d), 32'(ed));
      check($sformatf("rand%0d_u%0d_w%0d_a%0d_pulses", i, u, w, a), 32'(p), 32'(ep));
    end

    // start together with abort in IDLE must not be accepted
    @(negedge clk);
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    wraps_s[0] = 4'd1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    #1;
    check("start_abort_idle_ready", 32'(ready_s[0]), 32'd1);
    check("start_abort_idle_busy", 32'(busy_s[0]), 32'd0);

    // asynchronous reset between edges in RUN
    @(negedge clk);
    start_s[0] = 1'b1;
    wraps_s[0] = 4'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
    end
    #1;
    check("pre_reset_busy", 32'(busy_s[0]), 32'd1);
    check("pre_reset_cnt", 32'(cnt_s[0]), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_rdy_bsy_rst_cnt_done",
          32'({ready_s[0], busy_s[0], cnt_rst_s[0], cnt_s[0], done_s[0]}), 32'b10100);
    @(negedge clk);
    rst = 1'b1;
    run_check(0, 1, 0, d, p);
    check("after_reset_done_cycle", 32'(d), 32'd19);
    check("after_reset_pulses", 32'(p), 32'd16);

    // back-to-back runs with start held high
    p1 = 0;
    p2 = 0;
    @(negedge clk);
    start_s[0] = 1'b1;
    wraps_s[0] = 4'd1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 40) start_s[0] = 1'b0;
      #1;
      check($sformatf("b2b_cyc%0d_ready", k), 32'(ready_s[0]), 32'((k == 20) || (k == 40)));
      if (done_s[0]) dq.push_back(k);
      if (cnt_s[0]) begin
        if (k <= 20) p1++;
        else p2++;
      end
    end
    check("b2b_done_count", 32'(dq.size()), 32'd2);
    if (dq.size() >= 2) begin
      check("b2b_first_done", 32'(dq[0]), 32'd19);
      check("b2b_second_done", 32'(dq[1]), 32'd39);
    end
    check("b2b_first_pulses", 32'(p1), 32'd16);
    check("b2b_second_pulses", 32'(p2), 32'd16);
    @(negedge clk);
    #1;
    check("b2b_stays_idle", 32'(ready_s[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnt_sequencer.md
# cnt_sequencer

Run controller that sits directly upstream of `down_counter_4bit`: it accepts a run request, drives the counter's `cnt` enable at a prescaled rate and holds the counter cleared between runs. It watches the counter's `co` terminal-count output and stops after a requested number of full 16-step periods. It reports completion with a one-cycle `done` pulse and ready/start handshaking toward the requesting controller.

## Interface
- `WRAP_W`, 4: width of the `wraps` request field.
- `PRESCALE`, 1: `cnt` is asserted once every PRESCALE cycles while running. Legal range is 1..16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `start` input 1: run request; accepted on a rising edge where `start && ready`.
- `wraps` input WRAP_W: number of full counter periods to run; sampled on acceptance.
- `abort` input 1: cancels a run in progress.
- `co` input 1: counter terminal count, driven by `down_counter_4bit`. It is low exactly when the counter reads 0000.
- `ready` output 1: high only in IDLE.
- `busy` output 1: high in ARM, RUN and DONE.
- `cnt` output 1: decrement enable to the counter.
- `cnt_rst` output 1: active-high clear to the counter; high in IDLE.
- `done` output 1: one-cycle completion pulse.

## Operation
- States are IDLE, ARM, RUN and DONE.
- **IDLE**
  - Outputs: `ready`=1, `cnt_rst`=1, `cnt`=0.
  - On an accepted `start`, register `wraps` and go to ARM.
  - If `wraps`==0, go to DONE directly.
- **ARM:** one cycle with `cnt_rst`=0 and `cnt`=0; the prescaler is cleared. Then go to RUN.
- **RUN**
  - The prescaler counts 0..PRESCALE-1, starting at 0 on the first RUN cycle; tick = (prescaler==0).
  - `cnt_q` is `cnt` registered.
  - Arrival event = `cnt_q && !co`, meaning the counter has just reached zero. Each arrival increments the `arrivals` counter (width WRAP_W).
  - Final arrival = arrival event with `arrivals`==`wraps_reg`-1.
  - `cnt` = RUN && tick && !final arrival. This is combinational, so no decrement occurs past the last zero.
  - On the final arrival, go to DONE.
- **DONE:** `done`=1 for one cycle, `cnt`=0, then go to IDLE.
- **Counter start-up:** the counter leaves IDLE at zero with `co`=0, but `cnt_q`=0, so there is no false arrival on the first RUN cycle.
- **Abort:** when `abort` is high in ARM or RUN, go to IDLE next cycle. `done` is not pulsed, and `cnt` is forced 0 in that cycle.
  - `abort` in DONE is ignored (completion stands).
  - `abort` and `start` together in IDLE: the start is not accepted.
- **Pulse budget:** one run issues exactly 16×`wraps` `cnt` pulses. The counter ends at zero.

## Timing
- **Reset values:** state IDLE, `ready`=1, `busy`=0, `cnt`=0, `cnt_rst`=1, `done`=0. Prescaler, `arrivals` and `cnt_q` are 0.
- **Reset mid-run:** all of the above take effect immediately (asynchronous). No `done` pulse is issued.
- **Cycle numbering:** cycle k = k-th cycle after the accepting edge (cycle 1 = ARM).
- **Pulse placement:** the first `cnt` is in cycle 2. The last `cnt` is in cycle 2+(16W-1)·P, where W=`wraps` and P=PRESCALE.
- **Completion:** the final arrival is in the next cycle. `done` is in cycle (16W-1)·P+4, and `ready` returns the cycle after.
- **wraps==0:** `done` in cycle 1, `ready` in cycle 2.
- **Back-to-back runs:** the earliest next accept is the first IDLE cycle. Minimum gap between runs is one IDLE cycle, during which `cnt_rst` is high.

## Structure
- Shared package `cnt_seq_pkg`:
  - State encoding enum.
  - Constant `CNT_PERIOD`=16.
  - Prescaler-width function, clog2 of PRESCALE with a minimum of 1.
- Sub-module `tick_gen`:
  - Parameter PRESCALE.
  - Ports `clk`, `rst`, `clr`, `tick`.
  - Produces the tick at prescaler==0.
- The FSM, `arrivals` counter and `cnt_q` live in the top module.
- The bench wires `cnt_rst` OR `!rst` to the counter's reset.

## Test plan
- **Single wrap:** reset, then `wraps`=1, P=1 → `cnt` high in cycles 2..17 (16 pulses), `done` in cycle 19, counter reads 0, `ready` in cycle 20.
- **Multiple wraps with prescale:** `wraps`=3, P=4 → 48 `cnt` pulses spaced exactly 4 cycles apart, `done` in cycle 47·4+4=192, no `cnt` after cycle 190.
- **Zero wraps:** `wraps`=0 → no `cnt` pulses, `done` in cycle 1, `ready` in cycle 2.
- **Abort mid-run:** `abort` in cycle 10 of a `wraps`=2 run → `cnt`=0 in cycle 10, IDLE in cycle 11 with `cnt_rst`=1, `done` never pulses. `start` and `abort` together in IDLE → stays IDLE.
- **Asynchronous reset mid-run:** `rst` low between edges in RUN → `cnt`=0, `cnt_rst`=1, `ready`=1 immediately. The next run after release behaves as in the single-wrap case.
- **Back-to-back:** `start` held high with `wraps`=1 → second accept on the first IDLE cycle after `done`. Each run has exactly 16 pulses and its own `done`.
